// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the single-port scratch RAM.
package ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset, writing zero,
// then hands the memory over to the user port.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    ram_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                // While reset is held the pointer stays parked and nothing is written.
                clr_we  = RST_N;
                ptr_nxt = ptr + 1'b1;
                if (ptr == '1) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM with registered, write-first read data and a
// reset-time clear sequence that zeroes every word.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Din,
    input  logic              EN,
    input  logic              WE,
    output logic [DATA_W-1:0] DOut,
    output logic              Busy
);

    localparam int DEPTH_P = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .busy     (Busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign user_we = RST_N & ~Busy & EN & WE;
    assign wr_en   = clr_we | user_we;
    assign wr_addr = clr_we ? clr_addr : Addr;
    assign wr_data = clr_we ? '0 : Din;

    logic [DATA_W-1:0] mem [DEPTH_P];

    // NOTE: the array has no reset branch; clearing is done by the sequencer
    // so the storage still maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || Busy) begin
            DOut <= '0;
        end else if (EN) begin
            DOut <= WE ? Din : mem[Addr];
        end
    end

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: clear sequence, write/read, write-first,
// enable gating, reset during operation and address boundaries.
module tb_ram;
    import ram_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] Addr;
    logic [7:0] Din;
    logic       EN;
    logic       WE;
    logic [7:0] DOut;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    ram #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Addr  (Addr),
        .Din   (Din),
        .EN    (EN),
        .WE    (WE),
        .DOut  (DOut),
        .Busy  (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        EN = 1'b1; WE = 1'b1; Addr = a; Din = d;
        step();
        check(tag, {24'd0, DOut}, {24'd0, d});
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        EN = 1'b1; WE = 1'b0; Addr = a; Din = 8'h00;
        step();
        check(tag, {24'd0, DOut}, {24'd0, exp});
    endtask

    task automatic wait_idle(input int expect_cycles, input string tag);
        int n;
        n = 0;
        EN = 1'b0; WE = 1'b0;
        while (Busy === 1'b1 && n < 2 * DEPTH) begin
            step();
            n++;
        end
        check(tag, n, expect_cycles);
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; WE = 1'b0; Addr = 8'h00; Din = 8'h00;

        // Reset held for two cycles, then the full clear sequence.
        step();
        step();
        check("rst_dout", {24'd0, DOut}, 32'h0);
        check("rst_busy", {31'd0, Busy}, 32'h1);
        RST_N = 1'b1;
        wait_idle(DEPTH, "clear_cycles");
        do_read(8'h00, 8'h00, "clr_rd_00");
        do_read(8'h7F, 8'h00, "clr_rd_7f");
        do_read(8'hFF, 8'h00, "clr_rd_ff");

        // Back-to-back writes then reads.
        do_write(8'h01, 8'hA5, "wr_01");
        do_write(8'h02, 8'h3C, "wr_02");
        do_write(8'h03, 8'hFF, "wr_03");
        do_read(8'h01, 8'hA5, "rd_01");
        do_read(8'h02, 8'h3C, "rd_02");
        do_read(8'h03, 8'hFF, "rd_03");

        // Write-first readback.
        do_write(8'h10, 8'h5A, "wf_10");
        do_read(8'h10, 8'h5A, "rd_10");

        // Disabled port: write strobe ignored, output held.
        EN = 1'b0; WE = 1'b1; Addr = 8'h01; Din = 8'h00;
        step();
        check("en_hold", {24'd0, DOut}, 32'h5A);
        step();
        check("en_hold2", {24'd0, DOut}, 32'h5A);
        do_read(8'h01, 8'hA5, "en_rd_01");

        // Boundary addresses, no aliasing.
        do_write(8'hFF, 8'hC3, "wr_ff");
        do_write(8'h00, 8'h3C, "wr_00");
        do_read(8'hFF, 8'hC3, "rd_ff");
        do_read(8'h00, 8'h3C, "rd_00");

        // Reset mid-stream with an access in the reset cycle, then a write
        // attempt during the clear.
        EN = 1'b1; WE = 1'b1; Addr = 8'h30; Din = 8'h99;
        RST_N = 1'b0;
        step();
        check("mid_rst_dout", {24'd0, DOut}, 32'h0);
        check("mid_rst_busy", {31'd0, Busy}, 32'h1);
        RST_N = 1'b1;
        EN = 1'b1; WE = 1'b1; Addr = 8'h20; Din = 8'h77;
        step();
        check("clr_wr_dout", {24'd0, DOut}, 32'h0);
        check("clr_wr_busy", {31'd0, Busy}, 32'h1);
        wait_idle(DEPTH - 1, "reclear_cycles");
        do_read(8'h20, 8'h00, "reclr_rd_20");
        do_read(8'h01, 8'h00, "reclr_rd_01");
        do_read(8'h30, 8'h00, "reclr_rd_30");
        do_read(8'hFF, 8'h00, "reclr_rd_ff");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
